cpu_phase_sequencer: RTL

- Multi-cycle phase sequencer for the LEGv8 single-issue datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the req/ack handshakes to the instruction cache and data cache.
- Consumes the decoder's registered control flags and emits one-cycle enables for the decoder, ALU, register file and PC. Also keeps cycle and retired-instruction counters.

---
 rtl/cpu_phase_sequencer_pkg.sv | 22 ++
 rtl/cpu_phase_sequencer_handshake_timer.sv | 35 +++
 rtl/cpu_phase_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared phase encodings and defaults for the LEGv8 multi-cycle phase sequencer.
// The datapath and cache debug ports decode the same 3-bit phase values.
package cpu_phase_sequencer_pkg;

    localparam int CNT_W_DEFAULT   = 32;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_FETCH     = 3'd1,
        PH_DECODE    = 3'd2,
        PH_EXECUTE   = 3'd3,
        PH_MEM       = 3'd4,
        PH_WRITEBACK = 3'd5,
        PH_HALTED    = 3'd6
    } phase_e;

    function automatic logic phase_is_running(input phase_e p);
        return !((p == PH_IDLE) || (p == PH_HALTED));
    endfunction

endpackage

// File: rtl/cpu_phase_sequencer_handshake_timer.sv
// Wait-cycle counter shared by the instruction-fetch and data-cache handshakes.
// o_expired flags the last cycle a request may still be acked before it times out.
module cpu_phase_sequencer_handshake_timer
    import cpu_phase_sequencer_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int              CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en && (r_count != LIMIT)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = (r_count >= LAST);

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with cache handshakes,
// timeout fault halt and cycle/retired counters. All outputs are registered.
module cpu_phase_sequencer
    import cpu_phase_sequencer_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             haltReq,
    input  logic             fetchAck,
    input  logic             dataAck,
    input  logic             memRead,
    input  logic             memWrite,
    input  logic             regWriteFlag,
    input  logic             branch,
    input  logic             unconditionalBranch,
    input  logic             aluZero,
    output logic             fetchReq,
    output logic             irLoad,
    output logic             decodeEn,
    output logic             aluEn,
    output logic             dataReq,
    output logic             dataWe,
    output logic             regWriteEn,
    output logic             pcWrite,
    output logic             pcSrcBranch,
    output logic             running,
    output logic             fault,
    output logic [CNT_W-1:0] cycleCount,
    output logic [CNT_W-1:0] retiredCount
);

    phase_e           r_state;
    phase_e           w_next_state;
    logic             w_timeout;
    logic             w_expired;
    logic             w_timer_clear;
    logic             w_timer_en;
    logic             w_mem_write;
    logic             w_reg_write;
    logic             w_branch_taken;

    logic             r_mem_write;
    logic             r_reg_write;
    logic             r_branch_taken;
    logic             r_fetch_req;
    logic             r_ir_load;
    logic             r_decode_en;
    logic             r_alu_en;
    logic             r_data_req;
    logic             r_data_we;
    logic             r_reg_write_en;
    logic             r_pc_write;
    logic             r_pc_src_branch;
    logic             r_running;
    logic             r_fault;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_retired_count;

    // Decoder flags are captured in EXECUTE; later phases use the captured copy.
    assign w_mem_write    = (r_state == PH_EXECUTE) ? memWrite : r_mem_write;
    assign w_reg_write    = (r_state == PH_EXECUTE) ? regWriteFlag : r_reg_write;
    assign w_branch_taken = (r_state == PH_EXECUTE) ? (unconditionalBranch | (branch & aluZero))
                                                    : r_branch_taken;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            PH_IDLE:      if (start) w_next_state = PH_FETCH;
            PH_FETCH: begin
                if (fetchAck) begin
                    w_next_state = PH_DECODE;
                end else if (w_expired) begin
                    w_next_state = PH_HALTED;
                    w_timeout    = 1'b1;
                end
            end
            PH_DECODE:    w_next_state = PH_EXECUTE;
            PH_EXECUTE:   w_next_state = (memRead | memWrite) ? PH_MEM : PH_WRITEBACK;
            PH_MEM: begin
                if (dataAck) begin
                    w_next_state = PH_WRITEBACK;
                end else if (w_expired) begin
                    w_next_state = PH_HALTED;
                    w_timeout    = 1'b1;
                end
            end
            PH_WRITEBACK: w_next_state = haltReq ? PH_HALTED : PH_FETCH;
            PH_HALTED:    w_next_state = PH_HALTED;
            default:      w_next_state = PH_IDLE;
        endcase
    end

    assign w_timer_clear = (w_next_state != r_state) &&
                           ((w_next_state == PH_FETCH) || (w_next_state == PH_MEM));
    assign w_timer_en    = ((r_state == PH_FETCH) && !fetchAck) ||
                           ((r_state == PH_MEM)   && !dataAck);

    cpu_phase_sequencer_handshake_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_clear    (w_timer_clear),
        .i_count_en (w_timer_en),
        .o_expired  (w_expired)
    );

    // Each output is loaded with its value for the phase being entered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= PH_IDLE;
            r_mem_write     <= 1'b0;
            r_reg_write     <= 1'b0;
            r_branch_taken  <= 1'b0;
            r_fetch_req     <= 1'b0;
            r_ir_load       <= 1'b0;
            r_decode_en     <= 1'b0;
            r_alu_en        <= 1'b0;
            r_data_req      <= 1'b0;
            r_data_we       <= 1'b0;
            r_reg_write_en  <= 1'b0;
            r_pc_write      <= 1'b0;
            r_pc_src_branch <= 1'b0;
            r_running       <= 1'b0;
            r_fault         <= 1'b0;
            r_cycle_count   <= '0;
            r_retired_count <= '0;
        end else begin
            r_state         <= w_next_state;
            r_mem_write     <= w_mem_write;
            r_reg_write     <= w_reg_write;
            r_branch_taken  <= w_branch_taken;
            r_fetch_req     <= (w_next_state == PH_FETCH);
            r_ir_load       <= (r_state == PH_FETCH) && (w_next_state == PH_DECODE);
            r_decode_en     <= (w_next_state == PH_DECODE);
            r_alu_en        <= (w_next_state == PH_EXECUTE);
            r_data_req      <= (w_next_state == PH_MEM);
            r_data_we       <= (w_next_state == PH_MEM) && w_mem_write;
            r_reg_write_en  <= (w_next_state == PH_WRITEBACK) && w_reg_write && !w_mem_write;
            r_pc_write      <= (w_next_state == PH_WRITEBACK);
            r_pc_src_branch <= (w_next_state == PH_WRITEBACK) && w_branch_taken;
            r_running       <= phase_is_running(w_next_state);
            if (w_timeout) begin
                r_fault <= 1'b1;
            end
            if (r_running) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
            if (w_next_state == PH_WRITEBACK) begin
                r_retired_count <= r_retired_count + CNT_W'(1);
            end
        end
    end

    assign fetchReq     = r_fetch_req;
    assign irLoad       = r_ir_load;
    assign decodeEn     = r_decode_en;
    assign aluEn        = r_alu_en;
    assign dataReq      = r_data_req;
    assign dataWe       = r_data_we;
    assign regWriteEn   = r_reg_write_en;
    assign pcWrite      = r_pc_write;
    assign pcSrcBranch  = r_pc_src_branch;
    assign running      = r_running;
    assign fault        = r_fault;
    assign cycleCount   = r_cycle_count;
    assign retiredCount = r_retired_count;

endmodule
